booth_ctrl: RTL and testbench

BOOTH_CTRL -- requirements
Module: booth_ctrl

---
 rtl/booth_pkg.sv | 66 ++++++
 rtl/booth_ctrl.sv | 84 ++++++++
 tb/tb_booth_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: state encoding,
// iteration parameters and the state-to-control decode used by booth_ctrl.
package booth_pkg;

  localparam int unsigned N_ITER = 16;
  localparam int unsigned CNT_W  = 5;

  // 3'b111 is deliberately left unused; the controller recovers from it.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL  = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  typedef struct packed {
    logic ld_cnt;
    logic dec_cnt;
    logic ld_m;
    logic ld_q;
    logic clr_a;
    logic clr_qm1;
    logic ld_a;
    logic addsub;
    logic shift;
    logic busy;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode(input state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.ld_cnt  = 1'b1;
        c.ld_m    = 1'b1;
        c.ld_q    = 1'b1;
        c.clr_a   = 1'b1;
        c.clr_qm1 = 1'b1;
        c.busy    = 1'b1;
      end
      S_EVAL:  c.busy = 1'b1;
      S_ADD: begin
        c.ld_a   = 1'b1;
        c.addsub = 1'b1;
        c.busy   = 1'b1;
      end
      S_SUB: begin
        c.ld_a = 1'b1;
        c.busy = 1'b1;
      end
      S_SHIFT: begin
        c.shift   = 1'b1;
        c.dec_cnt = 1'b1;
        c.busy    = 1'b1;
      end
      S_DONE:  c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_ctrl.sv
// Booth multiplier sequencer: walks LOAD, then EVAL/ADD/SUB/SHIFT per bit
// pair, then DONE, driving the external counter and A/Q/M datapath.
module booth_ctrl #(
  parameter int unsigned N_ITER = booth_pkg::N_ITER,
  parameter int unsigned CNT_W  = booth_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             q0,
  input  logic             qm1,
  input  logic [CNT_W-1:0] cnt,
  output logic             ld_cnt,
  output logic             dec_cnt,
  output logic             ld_m,
  output logic             ld_q,
  output logic             clr_a,
  output logic             clr_qm1,
  output logic             ld_a,
  output logic             addsub,
  output logic             shift,
  output logic             busy,
  output logic             done
);

  import booth_pkg::*;

  if (N_ITER == 0 || N_ITER >= (1 << CNT_W)) begin : g_bad_cfg
    $error("booth_ctrl: N_ITER does not fit in CNT_W bits");
  end

  state_e state_q, state_d;
  ctrl_t  ctrl_q;

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_EVAL;
      S_EVAL: begin
        if (cnt == '0)
          state_d = S_DONE;
        else begin
          case ({q0, qm1})
            2'b01:   state_d = S_ADD;
            2'b10:   state_d = S_SUB;
            default: state_d = S_SHIFT;
          endcase
        end
      end
      S_ADD:   state_d = S_SHIFT;
      S_SUB:   state_d = S_SHIFT;
      // cnt still holds the pre-decrement value here, so 1 marks the last pass.
      S_SHIFT: state_d = (cnt == CNT_W'(1)) ? S_DONE : S_EVAL;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered as the decode of the next state, so they always
  // equal decode(state_q) without a combinational path from the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode(state_d);
    end
  end

  assign ld_cnt  = ctrl_q.ld_cnt;
  assign dec_cnt = ctrl_q.dec_cnt;
  assign ld_m    = ctrl_q.ld_m;
  assign ld_q    = ctrl_q.ld_q;
  assign clr_a   = ctrl_q.clr_a;
  assign clr_qm1 = ctrl_q.clr_qm1;
  assign ld_a    = ctrl_q.ld_a;
  assign addsub  = ctrl_q.addsub;
  assign shift   = ctrl_q.shift;
  assign busy    = ctrl_q.busy;
  assign done    = ctrl_q.done;

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl with a behavioural counter and A/Q/M datapath;
// expected products, latencies and shift counts go through a scoreboard queue.
module tb_booth_ctrl;
  import booth_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic q0, qm1;
  logic [CNT_W-1:0] cnt;
  logic ld_cnt, dec_cnt, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, shift, busy, done;

  booth_ctrl #(.N_ITER(N_ITER), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q0(q0), .qm1(qm1), .cnt(cnt),
    .ld_cnt(ld_cnt), .dec_cnt(dec_cnt), .ld_m(ld_m), .ld_q(ld_q),
    .clr_a(clr_a), .clr_qm1(clr_qm1), .ld_a(ld_a), .addsub(addsub),
    .shift(shift), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural datapath; A is one bit wider so M = -32768 subtracts correctly.
  logic signed [16:0] a_r = '0;
  logic [15:0] q_r = '0, m_r = '0, m_in = '0, q_in = '0;
  logic qm1_r = 1'b0;
  logic [CNT_W-1:0] cnt_r = '0;
  logic cnt_fault = 1'b0;

  always @(posedge clk) begin
    if (dec_cnt)     cnt_r <= cnt_r - 1'b1;
    else if (ld_cnt) cnt_r <= cnt_fault ? '0 : CNT_W'(N_ITER);
    if (ld_m) m_r <= m_in;
    if (ld_q) q_r <= q_in;
    if (clr_qm1) qm1_r <= 1'b0;
    if (clr_a)      a_r <= '0;
    else if (ld_a)  a_r <= addsub ? a_r + $signed({m_r[15], m_r}) : a_r - $signed({m_r[15], m_r});
    else if (shift) {a_r, q_r, qm1_r} <= {a_r[16], a_r, q_r};
  end

  assign q0  = q_r[0];
  assign qm1 = qm1_r;
  assign cnt = cnt_r;

  typedef struct {
    logic [31:0] prod;
    int          lat;
    int          shifts;
  } exp_t;
  exp_t sb[$];
  int done_cyc[$];
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic int exp_lat(input logic [15:0] q);
    int v;
    logic p;
    v = 0;
    p = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (q[i] != p) v++;
      p = q[i];
    end
    return 2 + 2 * int'(N_ITER) + v;
  endfunction

  task automatic push_op(input logic [15:0] m, input logic [15:0] q);
    logic signed [31:0] pm, pq, pr;
    exp_t e;
    pm = $signed(m);
    pq = $signed(q);
    pr = pm * pq;
    e.prod = pr;
    e.lat = exp_lat(q);
    e.shifts = int'(N_ITER);
    sb.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int lat_m = 0;
  int shifts_m = 0;
  exp_t e_m;
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_m = 0;
      shifts_m = 0;
    end else begin
      chk("ld_dec_overlap", 32'(ld_cnt & dec_cnt), 32'd0);
      if (busy || done) lat_m++;
      if (shift) shifts_m++;
      if (done) begin
        chk("done_busy_excl", 32'(busy), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(sb.size()), 32'd1);
        end else begin
          e_m = sb.pop_front();
          chk("product", {a_r[15:0], q_r}, e_m.prod);
          chk("latency", 32'(lat_m), 32'(e_m.lat));
          chk("shift_count", 32'(shifts_m), 32'(e_m.shifts));
        end
        done_cyc.push_back(cyc);
        done_cnt++;
        lat_m = 0;
        shifts_m = 0;
      end
    end
  end

  task automatic wait_done(input int limit);
    int n0;
    n0 = done_cnt;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt != n0) break;
    end
    chk("done_seen", 32'(done_cnt - n0), 32'd1);
  endtask

  task automatic run_op(input logic [15:0] m, input logic [15:0] q);
    @(posedge clk);
    #1;
    m_in = m;
    q_in = q;
    push_op(m, q);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(100);
  endtask

  initial begin
    exp_t ef;
    int n0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 32'({ld_cnt, dec_cnt, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, shift, busy, done}), 32'd0);
    rst_n = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_start", 32'({busy, done, ld_cnt}), 32'd0);

    run_op(16'd7, 16'hFFFD);
    run_op(16'h8000, 16'h8000);
    run_op(16'd3, 16'h5555);

    // Abort mid-operation with an asynchronous reset.
    @(posedge clk);
    #1;
    m_in = 16'd5;
    q_in = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (cnt == CNT_W'(8) && busy) break;
    end
    chk("busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("outs_in_reset", 32'({ld_cnt, dec_cnt, ld_m, ld_q, clr_a, clr_qm1, ld_a, addsub, shift, busy, done}), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(16'd2, 16'd9);

    // start held high: three back-to-back operations.
    @(posedge clk);
    #1;
    done_cyc.delete();
    m_in = 16'd7;
    q_in = 16'hFFFD;
    repeat (3) push_op(16'd7, 16'hFFFD);
    n0 = done_cnt;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done_cnt - n0 >= 3) break;
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_cnt - n0), 32'd3);
    if (done_cyc.size() >= 3) begin
      chk("held_gap_1", 32'(done_cyc[1] - done_cyc[0]), 32'(exp_lat(16'hFFFD) + 1));
      chk("held_gap_2", 32'(done_cyc[2] - done_cyc[1]), 32'(exp_lat(16'hFFFD) + 1));
    end
    sb.delete();

    // Counter fault: loads 0, so EVAL must go straight to DONE with no shift.
    repeat (2) @(posedge clk);
    #1;
    cnt_fault = 1'b1;
    m_in = 16'd4;
    q_in = 16'h0005;
    ef.prod = 32'h0000_0005;
    ef.lat = 3;
    ef.shifts = 0;
    sb.push_back(ef);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(10);
    cnt_fault = 1'b0;

    run_op(16'hFFFF, 16'hFFFF);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
